wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, LSU result buffer entries (power of two, >= 2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 3, consecutive ALU wins tolerated before the FIFO head is forced through.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have ports alu_valid (input, 1), alu_ready (output, 1), alu_addr (input, `RegAddrLen), alu_data (input, `RegLen): ALU result handshake.
REQ-006 SHALL have ports lsu_valid (input, 1), lsu_ready (output, 1), lsu_addr (input, `RegAddrLen), lsu_data (input, `RegLen): load result handshake.
REQ-007 SHALL have ports write_enable (output, 1), write_addr (output, `RegAddrLen), write_data (output, `RegLen), all registered, driving the register file write port.
REQ-008 SHALL have ports query_addr (input, `RegAddrLen) and query_pending (output, 1), combinational hazard query for decode.

Function
REQ-009 A transfer occurs on an input when valid and ready are both high at a rising edge.
REQ-010 lsu_ready SHALL equal (FIFO count < FIFO_DEPTH); no pass-through when full, even if a pop happens the same cycle.
REQ-011 An accepted LSU result SHALL be pushed at the tail of the FIFO; earliest write_enable is the edge after acceptance (latency 2 edges from offer).
REQ-012 force_fifo = FIFO non-empty AND starve_cnt >= STARVE_LIMIT; alu_ready SHALL equal NOT force_fifo.
REQ-013 At each edge: ALU transfer -> output register loads ALU addr/data, write_enable=1; else FIFO non-empty -> pop head, load it, write_enable=1 unless head is killed (then write_enable=0); else write_enable=0, addr/data hold.
REQ-014 ALU latency SHALL be one edge: accepted at edge N, write_enable high in cycle after N.
REQ-015 Push and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-016 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on an ALU transfer while the FIFO is non-empty, and clear on any pop or when the FIFO is empty.
REQ-017 On an ALU transfer with alu_addr != 0, every valid FIFO entry with matching addr SHALL be marked killed (younger ALU write wins); an LSU entry pushed in that same edge is not killed.
REQ-018 Killed entries SHALL still occupy a slot and be popped in order, consuming one arbitration cycle with write_enable=0.
REQ-019 query_pending SHALL be 1 iff query_addr != 0 and it matches a valid, unkilled FIFO entry or the output register while write_enable=1.
REQ-020 Address 0 writes SHALL be forwarded unchanged; the register file discards them.

Reset
REQ-021 While rst=1: write_enable=0, write_addr=0, write_data=0, FIFO count/pointers=0, all kill bits=0, starve_cnt=0; asynchronous, independent of clk.
REQ-022 Reset mid-operation SHALL discard all buffered LSU results; lsu_ready=1 and alu_ready=1 on the first cycle after release.

Configuration
REQ-023 Macro WB_STARVE_GUARD_EN SHALL select the starvation guard.
REQ-024 With WB_STARVE_GUARD_EN defined: REQ-012 and REQ-016 apply.
REQ-025 Without it: starve_cnt is not implemented, alu_ready is constantly 1, and the FIFO drains only in cycles with no ALU transfer (strict ALU priority).

Verification
REQ-026 ALU only: alu_valid=1, addr=5, data=0x1234 at edge 1 -> write_enable=1, write_addr=5, write_data=0x1234 after edge 1; 0 after edge 2.
REQ-027 LSU fill: 5 back-to-back LSU offers, alu_valid=0 held -> FIFO pops every edge, lsu_ready never drops, writes appear in order, each 2 edges after offer.
REQ-028 Full: alu_valid=1 every cycle, guard off, 4 LSU pushes -> lsu_ready=0 with count=4; drops alu_valid -> four LSU writes in push order.
REQ-029 Starvation (guard on): 1 LSU entry plus continuous ALU -> 3 ALU writes, then alu_ready=0 for one cycle and the LSU write issues.
REQ-030 Kill: LSU addr=7 buffered, ALU addr=7 data=0xAA accepted -> query_pending(7)=0 after the ALU write retires; killed pop gives write_enable=0; final x7=0xAA.
REQ-031 Reset with 3 entries buffered -> outputs 0 immediately, count=0, no stale write after release.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus bundle: ALU and LSU result handshakes, the
// registered register-file write port and the decode hazard query.
// The slave modport is the arbiter side, master is the producer/consumer side.

`ifndef RegAddrLen
`define RegAddrLen 5
`endif
`ifndef RegLen
`define RegLen 32
`endif

interface wb_arbiter_if;
   logic                   alu_valid;
   logic                   alu_ready;
   logic [`RegAddrLen-1:0] alu_addr;
   logic [`RegLen-1:0]     alu_data;

   logic                   lsu_valid;
   logic                   lsu_ready;
   logic [`RegAddrLen-1:0] lsu_addr;
   logic [`RegLen-1:0]     lsu_data;

   logic                   write_enable;
   logic [`RegAddrLen-1:0] write_addr;
   logic [`RegLen-1:0]     write_data;

   logic [`RegAddrLen-1:0] query_addr;
   logic                   query_pending;

   modport slave (
      input  alu_valid, alu_addr, alu_data,
      output alu_ready,
      input  lsu_valid, lsu_addr, lsu_data,
      output lsu_ready,
      output write_enable, write_addr, write_data,
      input  query_addr,
      output query_pending
   );

   modport master (
      output alu_valid, alu_addr, alu_data,
      input  alu_ready,
      output lsu_valid, lsu_addr, lsu_data,
      input  lsu_ready,
      input  write_enable, write_addr, write_data,
      output query_addr,
      input  query_pending
   );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results (one-edge latency, priority) with
// buffered LSU load results into a single registered register-file write port.
// Buffered LSU entries overwritten by a younger ALU write are marked killed and
// retire silently. Optional macro WB_STARVE_GUARD_EN adds a starvation guard
// that forces the FIFO head through after STARVE_LIMIT consecutive ALU wins;
// without it the ALU always has priority and the FIFO drains in idle cycles.

`ifndef RegAddrLen
`define RegAddrLen 5
`endif
`ifndef RegLen
`define RegLen 32
`endif

module wb_arbiter #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic         clk,
   input  logic         rst,
   wb_arbiter_if.slave  bus
);

   localparam int unsigned AW = `RegAddrLen;
   localparam int unsigned DW = `RegLen;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0]         fifo_addr_q [FIFO_DEPTH];
   logic [AW-1:0]         fifo_addr_d [FIFO_DEPTH];
   logic [DW-1:0]         fifo_data_q [FIFO_DEPTH];
   logic [DW-1:0]         fifo_data_d [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] kill_q, kill_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;

   logic                  write_enable_q, write_enable_d;
   logic [AW-1:0]         write_addr_q, write_addr_d;
   logic [DW-1:0]         write_data_q, write_data_d;

   logic [PW-1:0]         offset [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] entry_valid;
   logic                  fifo_empty, fifo_full;
   logic                  force_fifo;
   logic                  alu_xfer, lsu_xfer, pop;
   logic                  fifo_hit;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

`ifdef WB_STARVE_GUARD_EN
   localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_q, starve_d;

   assign force_fifo = !fifo_empty && (starve_q >= SW'(STARVE_LIMIT));

   // Count consecutive ALU wins over a waiting FIFO head; any pop or empty FIFO clears it
   always_comb begin
      starve_d = starve_q;
      if (pop || fifo_empty) begin
         starve_d = '0;
      end else if (alu_xfer && (starve_q < SW'(STARVE_LIMIT))) begin
         starve_d = starve_q + SW'(1);
      end
   end

   // Starvation counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   logic unused_starve_limit;

   assign unused_starve_limit = ^STARVE_LIMIT;
   assign force_fifo          = 1'b0;
`endif

   assign alu_xfer = bus.alu_valid && !force_fifo;
   assign lsu_xfer = bus.lsu_valid && !fifo_full;
   assign pop      = !alu_xfer && !fifo_empty;

   assign bus.alu_ready    = !force_fifo;
   assign bus.lsu_ready    = !fifo_full;
   assign bus.write_enable = write_enable_q;
   assign bus.write_addr   = write_addr_q;
   assign bus.write_data   = write_data_q;

   // Mark which physical slots hold live entries (distance from head below count)
   always_comb begin
      entry_valid = '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
         offset[i]      = PW'(i) - rd_ptr_q;
         entry_valid[i] = ({1'b0, offset[i]} < count_q);
      end
   end

   // FIFO bookkeeping: kill matching entries on ALU writes, pop head, push tail
   always_comb begin
      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      kill_d      = kill_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;

      if (alu_xfer && (bus.alu_addr != '0)) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (entry_valid[i] && (fifo_addr_q[i] == bus.alu_addr)) begin
               kill_d[i] = 1'b1;
            end
         end
      end

      if (pop) begin
         kill_d[rd_ptr_q] = 1'b0;
         rd_ptr_d         = rd_ptr_q + PW'(1);
      end

      if (lsu_xfer) begin
         fifo_addr_d[wr_ptr_q] = bus.lsu_addr;
         fifo_data_d[wr_ptr_q] = bus.lsu_data;
         kill_d[wr_ptr_q]      = 1'b0;
         wr_ptr_d              = wr_ptr_q + PW'(1);
      end

      case ({lsu_xfer, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Choose what the register-file write port carries next cycle
   always_comb begin
      write_enable_d = 1'b0;
      write_addr_d   = write_addr_q;
      write_data_d   = write_data_q;
      if (alu_xfer) begin
         write_enable_d = 1'b1;
         write_addr_d   = bus.alu_addr;
         write_data_d   = bus.alu_data;
      end else if (pop) begin
         write_enable_d = !kill_q[rd_ptr_q];
         write_addr_d   = fifo_addr_q[rd_ptr_q];
         write_data_d   = fifo_data_q[rd_ptr_q];
      end
   end

   // Hazard query: a live buffered write or the write currently on the port
   always_comb begin
      fifo_hit = 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
         if (entry_valid[i] && !kill_q[i] && (fifo_addr_q[i] == bus.query_addr)) begin
            fifo_hit = 1'b1;
         end
      end
   end

   assign bus.query_pending = (bus.query_addr != '0) &&
                              (fifo_hit || (write_enable_q && (write_addr_q == bus.query_addr)));

   // State registers; reset drops every buffered result and clears the write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            fifo_addr_q[i] <= '0;
            fifo_data_q[i] <= '0;
         end
         kill_q         <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         write_enable_q <= 1'b0;
         write_addr_q   <= '0;
         write_data_q   <= '0;
      end else begin
         fifo_addr_q    <= fifo_addr_d;
         fifo_data_q    <= fifo_data_d;
         kill_q         <= kill_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         write_enable_q <= write_enable_d;
         write_addr_q   <= write_addr_d;
         write_data_q   <= write_data_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter (FIFO_DEPTH=4, STARVE_LIMIT=3).
// Build with WB_STARVE_GUARD_EN defined to exercise the starvation guard
// scenario instead of the strict-priority full-FIFO scenario.

`ifndef RegAddrLen
`define RegAddrLen 5
`endif
`ifndef RegLen
`define RegLen 32
`endif

module tb_wb_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   passed = 0;
   int   total  = 0;
   logic [`RegLen-1:0] reg7_seen;

   wb_arbiter_if bus ();

   wb_arbiter #(
      .FIFO_DEPTH   (4),
      .STARVE_LIMIT (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   task automatic idle();
      bus.alu_valid  = 1'b0;
      bus.alu_addr   = '0;
      bus.alu_data   = '0;
      bus.lsu_valid  = 1'b0;
      bus.lsu_addr   = '0;
      bus.lsu_data   = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.write_enable === 1'b1 && bus.write_addr == 5'd7) reg7_seen = bus.write_data;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      bus.query_addr = '0;
      reg7_seen = '0;
      #12;
      total++; if (bus.write_enable !== 1'b0) $display("[TB] FAIL rst_we got %0h exp 0", bus.write_enable); else passed++;
      total++; if (bus.write_addr !== 5'd0) $display("[TB] FAIL rst_addr got %0h exp 0", bus.write_addr); else passed++;
      total++; if (bus.write_data !== 32'd0) $display("[TB] FAIL rst_data got %0h exp 0", bus.write_data); else passed++;
      total++; if (bus.lsu_ready !== 1'b1) $display("[TB] FAIL rst_lsu_ready got %0h exp 1", bus.lsu_ready); else passed++;
      total++; if (bus.alu_ready !== 1'b1) $display("[TB] FAIL rst_alu_ready got %0h exp 1", bus.alu_ready); else passed++;
      @(negedge clk);
      rst = 1'b0;
      tick();
      total++; if (bus.write_enable !== 1'b0) $display("[TB] FAIL rst_release_we got %0h exp 0", bus.write_enable); else passed++;
   endtask

   task automatic test_alu_only();
      bus.alu_valid = 1'b1;
      bus.alu_addr  = 5'd5;
      bus.alu_data  = 32'h1234;
      tick();
      total++; if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b1, 5'd5, 32'h1234})
         $display("[TB] FAIL alu_write got %0h/%0h/%0h exp 1/5/1234", bus.write_enable, bus.write_addr, bus.write_data); else passed++;
      bus.query_addr = 5'd5;
      bus.alu_valid  = 1'b0;
      #1;
      total++; if (bus.query_pending !== 1'b1) $display("[TB] FAIL alu_query_out got %0h exp 1", bus.query_pending); else passed++;
      tick();
      total++; if (bus.write_enable !== 1'b0) $display("[TB] FAIL alu_we_drop got %0h exp 0", bus.write_enable); else passed++;
      total++; if (bus.write_addr !== 5'd5) $display("[TB] FAIL alu_addr_hold got %0h exp 5", bus.write_addr); else passed++;
      total++; if (bus.query_pending !== 1'b0) $display("[TB] FAIL alu_query_idle got %0h exp 0", bus.query_pending); else passed++;
   endtask

   task automatic test_addr_zero();
      bus.alu_valid  = 1'b1;
      bus.alu_addr   = 5'd0;
      bus.alu_data   = 32'h5;
      bus.query_addr = 5'd0;
      tick();
      total++; if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b1, 5'd0, 32'h5})
         $display("[TB] FAIL zero_write got %0h/%0h/%0h exp 1/0/5", bus.write_enable, bus.write_addr, bus.write_data); else passed++;
      total++; if (bus.query_pending !== 1'b0) $display("[TB] FAIL zero_query got %0h exp 0", bus.query_pending); else passed++;
      idle();
      tick();
   endtask

   task automatic test_lsu_fill();
      for (int i = 0; i < 5; i++) begin
         bus.lsu_valid = 1'b1;
         bus.lsu_addr  = 5'(10 + i);
         bus.lsu_data  = 32'h100 + 32'(i);
         #1;
         total++; if (bus.lsu_ready !== 1'b1) $display("[TB] FAIL fill_ready%0d got %0h exp 1", i, bus.lsu_ready); else passed++;
         tick();
         if (i == 0) begin
            total++; if (bus.write_enable !== 1'b0) $display("[TB] FAIL fill_first_we got %0h exp 0", bus.write_enable); else passed++;
         end else begin
            total++; if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b1, 5'(9 + i), 32'h100 + 32'(i - 1)})
               $display("[TB] FAIL fill_write%0d got %0h/%0h/%0h exp 1/%0h/%0h", i, bus.write_enable, bus.write_addr,
                        bus.write_data, 9 + i, 32'h100 + 32'(i - 1)); else passed++;
         end
      end
      idle();
      tick();
      total++; if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b1, 5'd14, 32'h104})
         $display("[TB] FAIL fill_last got %0h/%0h/%0h exp 1/e/104", bus.write_enable, bus.write_addr, bus.write_data); else passed++;
      tick();
      total++; if (bus.write_enable !== 1'b0) $display("[TB] FAIL fill_drained got %0h exp 0", bus.write_enable); else passed++;
   endtask

`ifndef WB_STARVE_GUARD_EN
   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         bus.alu_valid = 1'b1;
         bus.alu_addr  = 5'd1;
         bus.alu_data  = 32'h50 + 32'(i);
         bus.lsu_valid = 1'b1;
         bus.lsu_addr  = 5'(20 + i);
         bus.lsu_data  = 32'h200 + 32'(i);
         #1;
         total++; if (bus.lsu_ready !== 1'b1) $display("[TB] FAIL full_ready%0d got %0h exp 1", i, bus.lsu_ready); else passed++;
         tick();
         total++; if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b1, 5'd1, 32'h50 + 32'(i)})
            $display("[TB] FAIL full_alu%0d got %0h/%0h/%0h", i, bus.write_enable, bus.write_addr, bus.write_data); else passed++;
      end
      bus.alu_data = 32'h54;
      bus.lsu_addr = 5'd24;
      bus.lsu_data = 32'h204;
      #1;
      total++; if (bus.lsu_ready !== 1'b0) $display("[TB] FAIL full_not_ready got %0h exp 0", bus.lsu_ready); else passed++;
      total++; if (bus.alu_ready !== 1'b1) $display("[TB] FAIL full_alu_ready got %0h exp 1", bus.alu_ready); else passed++;
      tick();
      total++; if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b1, 5'd1, 32'h54})
         $display("[TB] FAIL full_alu4 got %0h/%0h/%0h exp 1/1/54", bus.write_enable, bus.write_addr, bus.write_data); else passed++;
      total++; if (bus.lsu_ready !== 1'b0) $display("[TB] FAIL full_still_full got %0h exp 0", bus.lsu_ready); else passed++;
      idle();
      for (int j = 0; j < 4; j++) begin
         tick();
         total++; if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b1, 5'(20 + j), 32'h200 + 32'(j)})
            $display("[TB] FAIL full_drain%0d got %0h/%0h/%0h exp 1/%0h/%0h", j, bus.write_enable, bus.write_addr,
                     bus.write_data, 20 + j, 32'h200 + 32'(j)); else passed++;
         if (j == 0) begin
            total++; if (bus.lsu_ready !== 1'b1) $display("[TB] FAIL full_ready_after_pop got %0h exp 1", bus.lsu_ready); else passed++;
         end
      end
      tick();
      total++; if (bus.write_enable !== 1'b0) $display("[TB] FAIL full_no_extra got %0h exp 0", bus.write_enable); else passed++;
   endtask
`else
   task automatic test_starvation();
      bus.lsu_valid = 1'b1;
      bus.lsu_addr  = 5'd30;
      bus.lsu_data  = 32'h300;
      tick();
      bus.lsu_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         bus.alu_valid = 1'b1;
         bus.alu_addr  = 5'd2;
         bus.alu_data  = 32'h60 + 32'(j);
         #1;
         total++; if (bus.alu_ready !== 1'b1) $display("[TB] FAIL starve_ready%0d got %0h exp 1", j, bus.alu_ready); else passed++;
         tick();
         total++; if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b1, 5'd2, 32'h60 + 32'(j)})
            $display("[TB] FAIL starve_alu%0d got %0h/%0h/%0h", j, bus.write_enable, bus.write_addr, bus.write_data); else passed++;
      end
      bus.alu_data = 32'h63;
      #1;
      total++; if (bus.alu_ready !== 1'b0) $display("[TB] FAIL starve_forced got %0h exp 0", bus.alu_ready); else passed++;
      tick();
      total++; if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b1, 5'd30, 32'h300})
         $display("[TB] FAIL starve_lsu got %0h/%0h/%0h exp 1/1e/300", bus.write_enable, bus.write_addr, bus.write_data); else passed++;
      total++; if (bus.alu_ready !== 1'b1) $display("[TB] FAIL starve_release got %0h exp 1", bus.alu_ready); else passed++;
      tick();
      total++; if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b1, 5'd2, 32'h63})
         $display("[TB] FAIL starve_alu_resume got %0h/%0h/%0h exp 1/2/63", bus.write_enable, bus.write_addr, bus.write_data); else passed++;
      idle();
      tick();
   endtask
`endif

   task automatic test_kill();
      bus.alu_valid  = 1'b1;
      bus.alu_addr   = 5'd3;
      bus.alu_data   = 32'h33;
      bus.lsu_valid  = 1'b1;
      bus.lsu_addr   = 5'd7;
      bus.lsu_data   = 32'h77;
      tick();
      total++; if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b1, 5'd3, 32'h33})
         $display("[TB] FAIL kill_alu3 got %0h/%0h/%0h exp 1/3/33", bus.write_enable, bus.write_addr, bus.write_data); else passed++;
      bus.lsu_valid  = 1'b0;
      bus.query_addr = 5'd7;
      bus.alu_addr   = 5'd7;
      bus.alu_data   = 32'hAA;
      #1;
      total++; if (bus.query_pending !== 1'b1) $display("[TB] FAIL kill_pend_buf got %0h exp 1", bus.query_pending); else passed++;
      tick();
      total++; if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b1, 5'd7, 32'hAA})
         $display("[TB] FAIL kill_alu7 got %0h/%0h/%0h exp 1/7/aa", bus.write_enable, bus.write_addr, bus.write_data); else passed++;
      idle();
      tick();
      total++; if (bus.write_enable !== 1'b0) $display("[TB] FAIL kill_pop_we got %0h exp 0", bus.write_enable); else passed++;
      total++; if (bus.query_pending !== 1'b0) $display("[TB] FAIL kill_query_clear got %0h exp 0", bus.query_pending); else passed++;
      tick();
      total++; if (reg7_seen !== 32'hAA) $display("[TB] FAIL kill_final_x7 got %0h exp aa", reg7_seen); else passed++;
   endtask

   task automatic test_same_edge();
      bus.alu_valid = 1'b1;
      bus.alu_addr  = 5'd9;
      bus.alu_data  = 32'h99;
      bus.lsu_valid = 1'b1;
      bus.lsu_addr  = 5'd9;
      bus.lsu_data  = 32'h19;
      tick();
      total++; if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b1, 5'd9, 32'h99})
         $display("[TB] FAIL same_alu got %0h/%0h/%0h exp 1/9/99", bus.write_enable, bus.write_addr, bus.write_data); else passed++;
      idle();
      tick();
      total++; if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b1, 5'd9, 32'h19})
         $display("[TB] FAIL same_lsu_alive got %0h/%0h/%0h exp 1/9/19", bus.write_enable, bus.write_addr, bus.write_data); else passed++;
      tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         bus.alu_valid = 1'b1;
         bus.alu_addr  = 5'd4;
         bus.alu_data  = 32'h40 + 32'(i);
         bus.lsu_valid = 1'b1;
         bus.lsu_addr  = 5'(25 + i);
         bus.lsu_data  = 32'h250 + 32'(i);
         tick();
      end
      idle();
      rst = 1'b1;
      #1;
      total++; if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b0, 5'd0, 32'd0})
         $display("[TB] FAIL mid_rst_outputs got %0h/%0h/%0h exp 0/0/0", bus.write_enable, bus.write_addr, bus.write_data); else passed++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if ({bus.lsu_ready, bus.alu_ready} !== 2'b11) $display("[TB] FAIL mid_rst_ready got %0b exp 11", {bus.lsu_ready, bus.alu_ready}); else passed++;
      tick();
      total++; if (bus.write_enable !== 1'b0) $display("[TB] FAIL mid_rst_stale1 got %0h exp 0", bus.write_enable); else passed++;
      tick();
      total++; if (bus.write_enable !== 1'b0) $display("[TB] FAIL mid_rst_stale2 got %0h exp 0", bus.write_enable); else passed++;
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_alu_only();
      test_addr_zero();
      test_lsu_fill();
`ifndef WB_STARVE_GUARD_EN
      test_full();
`else
      test_starvation();
`endif
      test_kill();
      test_same_edge();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
